// File: rtl/mod_addsub_serial_pkg.sv
// Shared field constants and types for the elliptic-curve datapath.
// Package elliptic_curve_structs: secp256k1 prime, field-element type,
// add/sub FSM state type and a limb-count helper.
package elliptic_curve_structs;

    localparam int P_WIDTH = 256;

    // secp256k1 prime: 2^256 - 2^32 - 977
    localparam logic [P_WIDTH-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef logic [P_WIDTH-1:0] fe_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } addsub_state_t;

    // Number of limb cycles needed to cover a full operand.
    function automatic int limb_count(input int pw, input int lw);
        return pw / lw;
    endfunction

endpackage

// File: rtl/mod_addsub_serial_limb_addsub.sv
// One limb of a ripple add/subtract chain.
// Add:      {cout, r} = x + y + cin
// Subtract: r = x - y - cin, cout = borrow out
module limb_addsub #(
    parameter int W = 64
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         cin_i,
    input  logic         sub_i,
    output logic [W-1:0] r_o,
    output logic         cout_o
);

    logic [W:0] ext_s;

    // Widen by one bit so the top bit is the carry (add) or borrow (sub).
    always_comb begin
        ext_s = '0;
        if (sub_i) begin
            ext_s = {1'b0, x_i} - {1'b0, y_i} - {{W{1'b0}}, cin_i};
        end else begin
            ext_s = {1'b0, x_i} + {1'b0, y_i} + {{W{1'b0}}, cin_i};
        end
    end

    assign r_o    = ext_s[W-1:0];
    assign cout_o = ext_s[W];

endmodule

// File: rtl/mod_addsub_serial.sv
// Limb-serial modular adder/subtractor: sum = (a +/- b) mod MODULUS.
// Chain 0 forms a +/- b, chain 1 forms the corrected value (r0 -/+ MODULUS)
// in the same cycle; the final carries pick the reduced result.
// Optional feature macro: MOD_ADDSUB_RANGE_CHECK_EN adds the Err port and
// limb-serial compares of a and b against MODULUS.
module mod_addsub_serial #(
    parameter int                 P_WIDTH    = elliptic_curve_structs::P_WIDTH,
    parameter int                 LIMB_WIDTH = 64,
    parameter logic [P_WIDTH-1:0] MODULUS    = elliptic_curve_structs::P
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               op,
    input  logic [P_WIDTH-1:0] a,
    input  logic [P_WIDTH-1:0] b,
    output logic [P_WIDTH-1:0] sum,
    output logic               Done,
    output logic               Busy
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    ,
    output logic               Err
`endif
);

    import elliptic_curve_structs::*;

    localparam int NLIMBS = limb_count(P_WIDTH, LIMB_WIDTH);
    localparam int CNT_W  = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NLIMBS - 1);

    generate
        if ((P_WIDTH % LIMB_WIDTH) != 0) begin : g_bad_limb_width
            $error("LIMB_WIDTH must divide P_WIDTH");
        end
    endgenerate

    // State and datapath registers
    addsub_state_t      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [P_WIDTH-1:0] a_q;
    logic [P_WIDTH-1:0] b_q;
    logic [P_WIDTH-1:0] p_q;
    logic [P_WIDTH-1:0] r0_q;
    logic [P_WIDTH-1:0] r1_q;
    logic               op_q;
    logic               c0_q;
    logic               c1_q;
    logic [P_WIDTH-1:0] sum_q;
    logic               done_q;
    logic               busy_q;

    // Current limb slices (LSB limb of the shifting registers)
    logic [LIMB_WIDTH-1:0] a_limb_s;
    logic [LIMB_WIDTH-1:0] b_limb_s;
    logic [LIMB_WIDTH-1:0] p_limb_s;
    logic [LIMB_WIDTH-1:0] r0_limb_s;
    logic [LIMB_WIDTH-1:0] r1_limb_s;
    logic                  c0_out_s;
    logic                  c1_out_s;

    // Next values of the result registers and the selected result
    logic [P_WIDTH-1:0] r0_d;
    logic [P_WIDTH-1:0] r1_d;
    logic [P_WIDTH-1:0] sum_d;

    assign a_limb_s = a_q[LIMB_WIDTH-1:0];
    assign b_limb_s = b_q[LIMB_WIDTH-1:0];
    assign p_limb_s = p_q[LIMB_WIDTH-1:0];

    // Chain 0: a +/- b
    limb_addsub #(.W(LIMB_WIDTH)) u_chain0 (
        .x_i    (a_limb_s),
        .y_i    (b_limb_s),
        .cin_i  (c0_q),
        .sub_i  (op_q),
        .r_o    (r0_limb_s),
        .cout_o (c0_out_s)
    );

    // Chain 1: r0 - MODULUS for add, r0 + MODULUS for subtract
    limb_addsub #(.W(LIMB_WIDTH)) u_chain1 (
        .x_i    (r0_limb_s),
        .y_i    (p_limb_s),
        .cin_i  (c1_q),
        .sub_i  (~op_q),
        .r_o    (r1_limb_s),
        .cout_o (c1_out_s)
    );

    // New limbs enter at the top; after NLIMBS shifts the word is complete.
    assign r0_d = (r0_q >> LIMB_WIDTH) | (P_WIDTH'(r0_limb_s) << (P_WIDTH - LIMB_WIDTH));
    assign r1_d = (r1_q >> LIMB_WIDTH) | (P_WIDTH'(r1_limb_s) << (P_WIDTH - LIMB_WIDTH));

    // Pick the reduced result from the final carry/borrow of both chains.
    always_comb begin
        sum_d = r0_d;
        if (op_q) begin
            // a - b went negative: add MODULUS back
            if (c0_out_s) begin
                sum_d = r1_d;
            end else begin
                sum_d = r0_d;
            end
        end else begin
            // a + b overflowed the word or is >= MODULUS: take r0 - MODULUS
            if (c0_out_s | ~c1_out_s) begin
                sum_d = r1_d;
            end else begin
                sum_d = r0_d;
            end
        end
    end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    logic                  bwa_q;
    logic                  bwb_q;
    logic                  err_q;
    logic [LIMB_WIDTH-1:0] rca_diff_s;
    logic [LIMB_WIDTH-1:0] rcb_diff_s;
    logic                  bwa_out_s;
    logic                  bwb_out_s;
    logic                  err_d;

    // Range-check chain for a: borrow out of a - MODULUS
    limb_addsub #(.W(LIMB_WIDTH)) u_range_a (
        .x_i    (a_limb_s),
        .y_i    (p_limb_s),
        .cin_i  (bwa_q),
        .sub_i  (1'b1),
        .r_o    (rca_diff_s),
        .cout_o (bwa_out_s)
    );

    // Range-check chain for b: borrow out of b - MODULUS
    limb_addsub #(.W(LIMB_WIDTH)) u_range_b (
        .x_i    (b_limb_s),
        .y_i    (p_limb_s),
        .cin_i  (bwb_q),
        .sub_i  (1'b1),
        .r_o    (rcb_diff_s),
        .cout_o (bwb_out_s)
    );

    // No final borrow means the operand is >= MODULUS.
    assign err_d = ~bwa_out_s | ~bwb_out_s;

    // Range-check borrows and the sticky error flag
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bwa_q <= 1'b0;
            bwb_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        bwa_q <= 1'b0;
                        bwb_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                CALC: begin
                    bwa_q <= bwa_out_s;
                    bwb_q <= bwb_out_s;
                    if (cnt_q == CNT_LAST) begin
                        err_q <= err_d;
                    end
                end
                DONE: begin
                    bwa_q <= 1'b0;
                    bwb_q <= 1'b0;
                end
                default: begin
                    bwa_q <= 1'b0;
                    bwb_q <= 1'b0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    assign Err = err_q;
`endif

    // Control FSM with limb counter, shifting operands and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            op_q    <= 1'b0;
            c0_q    <= 1'b0;
            c1_q    <= 1'b0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        a_q     <= a;
                        b_q     <= b;
                        p_q     <= MODULUS;
                        op_q    <= op;
                        c0_q    <= 1'b0;
                        c1_q    <= 1'b0;
                        r0_q    <= '0;
                        r1_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    a_q   <= a_q >> LIMB_WIDTH;
                    b_q   <= b_q >> LIMB_WIDTH;
                    p_q   <= p_q >> LIMB_WIDTH;
                    r0_q  <= r0_d;
                    r1_q  <= r1_d;
                    c0_q  <= c0_out_s;
                    c1_q  <= c1_out_s;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= sum_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign Done = done_q;
    assign Busy = busy_q;

endmodule
